// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: device FSM states and frame lengths (also used by the host side).
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_INHIBIT,
        ST_RX,
        ST_ACK,
        ST_STOPW
    } ps2_dev_state_t;

    localparam int TX_BITS = 11;  // start, 8 data, parity, stop
    localparam int RX_BITS = 10;  // 8 data, parity, stop (start is the host RTS)

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_slot_timer.sv
// PS/2 bit-slot timer: phase H (clock released) for HALF_PER cycles, then phase L.
// No latency beyond the counter register; restart holds the count at the slot start.
module ps2_slot_timer #(
    parameter int HALF_PER = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase_l,
    output logic end_h,
    output logic pre_end,
    output logic end_slot
);

    localparam int CW = $clog2(2 * HALF_PER);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart || end_slot) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign phase_l  = (cnt >= CW'(HALF_PER));
    assign end_h    = (cnt == CW'(HALF_PER - 1));
    assign pre_end  = (cnt == CW'(2 * HALF_PER - 2));
    assign end_slot = (cnt == CW'(2 * HALF_PER - 1));

endmodule

// File: rtl/ps2_device.sv
// PS/2 device side: clocks bytes to the host, receives host commands and ACKs them.
// One byte of TX buffering; tx_ready low while a byte is pending, extra requests ignored.
module ps2_device
    import ps2_pkg::*;
#(
    parameter int HALF_PER = 1250,
    parameter int IDLE_CYC = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_d,
    input  logic       ps2_data_d,
    output logic       ps2_clk_q,
    output logic       ps2_data_q,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int IW = $clog2(IDLE_CYC + 1);

    ps2_dev_state_t       state;
    logic [1:0]           clk_sync;
    logic [1:0]           data_sync;
    logic                 clk_s;
    logic                 data_s;
    logic [3:0]           bit_cnt;
    logic [IW-1:0]        idle_cnt;
    logic [7:0]           tx_byte;
    logic [TX_BITS-1:0]   tx_shift;
    logic [RX_BITS-1:0]   rx_shift;
    logic                 clocked;
    logic                 phase_l;
    logic                 end_h;
    logic                 pre_end;
    logic                 end_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_d};
            data_sync <= {data_sync[0], ps2_data_d};
        end
    end

    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    assign clocked = (state == ST_TX) || (state == ST_RX) ||
                     (state == ST_ACK) || (state == ST_STOPW);

    // Outside clocked states the timer sits at zero so a new frame starts on a clean slot.
    ps2_slot_timer #(.HALF_PER(HALF_PER)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (!clocked),
        .phase_l  (phase_l),
        .end_h    (end_h),
        .pre_end  (pre_end),
        .end_slot (end_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ps2_clk_q  <= 1'b0;
            ps2_data_q <= 1'b0;
            tx_ready   <= 1'b1;
            tx_byte    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
        end else begin
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            // Next cycle lies in phase L; early exits below override to release the clock.
            ps2_clk_q <= clocked && (end_h || (phase_l && !end_slot));

            if (tx_req && tx_ready) begin
                tx_ready <= 1'b0;
                tx_byte  <= tx_data;
            end

            if (state == ST_IDLE && clk_s && data_s) begin
                if (idle_cnt != IW'(IDLE_CYC)) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (!clk_s) begin
                        state <= ST_INHIBIT;
                    end else if (!tx_ready && idle_cnt == IW'(IDLE_CYC)) begin
                        state      <= ST_TX;
                        tx_shift   <= {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
                        ps2_data_q <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end
                ST_TX: begin
                    if (end_h && !clk_s) begin
                        // Host inhibit: drop the frame, keep the byte for a full resend.
                        state      <= ST_INHIBIT;
                        ps2_clk_q  <= 1'b0;
                        ps2_data_q <= 1'b0;
                    end else if (end_slot) begin
                        if (bit_cnt == 4'(TX_BITS - 1)) begin
                            state      <= ST_IDLE;
                            ps2_data_q <= 1'b0;
                            tx_ready   <= 1'b1;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            tx_shift   <= tx_shift >> 1;
                            ps2_data_q <= ~tx_shift[1];
                        end
                    end
                end
                ST_INHIBIT: begin
                    ps2_data_q <= 1'b0;
                    if (clk_s) begin
                        state   <= data_s ? ST_IDLE : ST_RX;
                        bit_cnt <= '0;
                    end
                end
                ST_RX: begin
                    if (end_h) begin
                        if (!clk_s) begin
                            state     <= ST_INHIBIT;
                            ps2_clk_q <= 1'b0;
                        end else begin
                            rx_shift <= {data_s, rx_shift[RX_BITS-1:1]};
                        end
                    end else if (end_slot) begin
                        if (bit_cnt == 4'(RX_BITS - 1)) begin
                            bit_cnt <= '0;
                            if ((^rx_shift[8:0]) && rx_shift[9]) begin
                                state      <= ST_ACK;
                                ps2_data_q <= 1'b1;
                            end else begin
                                state  <= ST_STOPW;
                                rx_err <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (end_h && !clk_s) begin
                        state      <= ST_INHIBIT;
                        ps2_clk_q  <= 1'b0;
                        ps2_data_q <= 1'b0;
                    end else if (pre_end) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift[7:0];
                    end else if (end_slot) begin
                        state      <= ST_IDLE;
                        ps2_data_q <= 1'b0;
                    end
                end
                ST_STOPW: begin
                    // Keep clocking until the host lets data float high, bounded to 8 slots.
                    if (end_h) begin
                        if (data_s || bit_cnt == 4'd7) begin
                            state     <= ST_IDLE;
                            ps2_clk_q <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: host BFM on the open-collector bus plus scoreboard monitor.
module tb_ps2_device;

    localparam int HP   = 4;
    localparam int IC   = 8;
    localparam int SLOT = 2 * HP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_d;
    logic       ps2_data_d;
    logic       ps2_clk_q;
    logic       ps2_data_q;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req  = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    logic h_clk     = 1'b0;
    logic h_data    = 1'b0;
    logic host_busy = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [10:0] exp_tx[$];
    logic [7:0]  exp_rx[$];
    int          exp_err = 0;

    assign ps2_clk_d  = ~(ps2_clk_q | h_clk);
    assign ps2_data_d = ~(ps2_data_q | h_data);

    always #5 clk = ~clk;

    ps2_device #(.HALF_PER(HP), .IDLE_CYC(IC)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_d  (ps2_clk_d),
        .ps2_data_d (ps2_data_d),
        .ps2_clk_q  (ps2_clk_q),
        .ps2_data_q (ps2_data_q),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err)
    );

    function automatic logic [10:0] frame(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h, expected no such event", name, act);
    endtask

    task automatic wait_fall(input int bound, output bit ok);
        logic p;
        ok = 1'b0;
        p  = ps2_clk_d;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (p && !ps2_clk_d) ok = 1'b1;
            p = ps2_clk_d;
        end
    endtask

    task automatic wait_tx_ready(input int bound);
        for (int i = 0; i < bound && !tx_ready; i++) @(negedge clk);
        check("tx_ready_after_stop", tx_ready, 1);
    endtask

    // Host -> device frame. stop_after > 0 returns after that many device clock falls, bus still held.
    task automatic host_send(input logic [7:0] b, input logic bad_par, input logic with_tx,
                             input logic [7:0] txb, input int stop_after,
                             output logic ack_edge, output logic ack_low);
        logic [9:0] bits;
        bit ok;
        ack_edge = 1'b0;
        ack_low  = 1'b0;
        bits     = {1'b1, (~^b) ^ bad_par, b};
        host_busy = 1'b1;
        h_clk     = 1'b1;
        @(negedge clk);
        if (with_tx) begin
            tx_data = txb;
            tx_req  = 1'b1;
            @(negedge clk);
            tx_req  = 1'b0;
        end
        repeat (12) @(negedge clk);
        h_data = 1'b1;
        repeat (4) @(negedge clk);
        h_clk = 1'b0;
        @(negedge clk);
        h_data = ~bits[0];
        for (int k = 1; k <= 10; k++) begin
            wait_fall(4 * SLOT, ok);
            if (!ok) begin
                fail_now("host_clk_edge_timeout", k);
                h_data    = 1'b0;
                host_busy = 1'b0;
                return;
            end
            if (k == stop_after) return;
            if (k < 10) h_data = ~bits[k];
        end
        wait_fall(3 * SLOT, ok);
        ack_edge = ok;
        ack_low  = ok & ~ps2_data_d;
        repeat (2) @(negedge clk);
        h_data    = 1'b0;
        host_busy = 1'b0;
    endtask

    // Scoreboard monitor: decodes device->host frames and consumes rx pulses.
    initial begin
        logic [10:0] mframe;
        int          mbits;
        logic        mprev;
        mframe = '0;
        mbits  = 0;
        mprev  = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_valid && rx_err) fail_now("rx_valid_and_rx_err", {rx_valid, rx_err});
            if (rx_valid) begin
                if (exp_rx.size() == 0) fail_now("unexpected_rx_valid", rx_data);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (rx_err) begin
                check("rx_err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
            if (host_busy || rst) begin
                mbits = 0;
            end else if (mprev && !ps2_clk_d) begin
                mframe[mbits] = ps2_data_d;
                mbits++;
                if (mbits == 11) begin
                    if (exp_tx.size() == 0) fail_now("unexpected_tx_frame", mframe);
                    else check("tx_frame", mframe, exp_tx.pop_front());
                    mbits = 0;
                end
            end
            mprev = ps2_clk_d;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1);
    end

    initial begin
        logic ae, al;
        bit   ok;

        repeat (3) @(negedge clk);
        check("rst_clk_q", ps2_clk_q, 0);
        check("rst_data_q", ps2_data_q, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_err", rx_err, 0);
        rst = 1'b0;

        // Device sends 0x1C (three ones -> parity 0); a second request while busy is dropped.
        exp_tx.push_back(frame(8'h1C, 1'b0));
        tx_data = 8'h1C; tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        check("tx_ready_busy", tx_ready, 0);
        tx_data = 8'h99; tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        wait_tx_ready(20 * SLOT);
        repeat (4 * SLOT) @(negedge clk);
        check("tx_1c_drained", exp_tx.size(), 0);

        // Host sends 0xED with good parity.
        exp_rx.push_back(8'hED);
        host_send(8'hED, 1'b0, 1'b0, 8'h00, 0, ae, al);
        check("ack_edge_ed", ae, 1);
        check("ack_low_ed", al, 1);
        repeat (SLOT) @(negedge clk);
        check("rx_ed_drained", exp_rx.size(), 0);

        // Host sends 0xF4 with bad parity: error pulse, no ACK clock.
        exp_err++;
        host_send(8'hF4, 1'b1, 1'b0, 8'h00, 0, ae, al);
        check("nack_edge_f4", ae, 0);
        repeat (2 * SLOT) @(negedge clk);
        check("err_f4_drained", exp_err, 0);

        // Device sends 0xAA; host inhibits during data bit 5, device resends whole frame.
        exp_tx.push_back(frame(8'hAA, 1'b1));
        tx_data = 8'hAA; tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_fall(4 * SLOT, ok);
            if (!ok) fail_now("aa_fall_timeout", k);
        end
        ok = 1'b0;
        for (int i = 0; i < 2 * SLOT && !ok; i++) begin
            @(negedge clk);
            if (ps2_clk_d) ok = 1'b1;
        end
        host_busy = 1'b1;
        h_clk     = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_clk_released", ps2_clk_q, 0);
        check("abort_data_released", ps2_data_q, 0);
        check("abort_byte_pending", tx_ready, 0);
        repeat (10) @(negedge clk);
        h_clk     = 1'b0;
        host_busy = 1'b0;
        wait_tx_ready(40 * SLOT);
        repeat (SLOT) @(negedge clk);
        check("tx_aa_drained", exp_tx.size(), 0);

        // Host sends 0xFF while device requests 0xFA: host frame first, then 0xFA.
        exp_rx.push_back(8'hFF);
        exp_tx.push_back(frame(8'hFA, 1'b1));
        host_send(8'hFF, 1'b0, 1'b1, 8'hFA, 0, ae, al);
        check("ack_low_ff", al, 1);
        wait_tx_ready(40 * SLOT);
        repeat (SLOT) @(negedge clk);
        check("rx_ff_drained", exp_rx.size(), 0);
        check("tx_fa_drained", exp_tx.size(), 0);

        // Reset during host frame bit 3 (clock low phase) with a byte pending.
        host_send(8'h3C, 1'b0, 1'b1, 8'h55, 4, ae, al);
        @(negedge clk);
        check("pre_rst_clk_q", ps2_clk_q, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_q", ps2_clk_q, 0);
        check("mid_rst_data_q", ps2_data_q, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        rst       = 1'b0;
        h_data    = 1'b0;
        host_busy = 1'b0;
        repeat (15 * SLOT) @(negedge clk);
        check("final_tx_q", exp_tx.size(), 0);
        check("final_rx_q", exp_rx.size(), 0);
        check("final_err_q", exp_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
